mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 25 ++
 rtl/mem_resp_array.sv | 64 ++++++
 rtl/mem_responder.sv | 138 +++++++++++++
 tb/tb_mem_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types for the memory responder: FSM state encoding, access-size
// encodings and the alignment predicate.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Big-endian byte storage with size-aware lane merge on write and
// right-justified, zero-extended extraction on read. Storage is not reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    size_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [AW-1:0] base_s;
  logic [AW-1:0] a1_s;
  logic [AW-1:0] a2_s;
  logic [AW-1:0] a3_s;

  // Low address bits are dropped to the natural alignment of the access
  always_comb begin
    base_s = addr_i;
    case (size_i)
      SZ_BYTE: base_s = addr_i;
      SZ_HALF: base_s[0] = 1'b0;
      default: base_s[1:0] = 2'b00;
    endcase
  end

  assign a1_s = base_s + AW'(1);
  assign a2_s = base_s + AW'(2);
  assign a3_s = base_s + AW'(3);

  always_comb begin
    rdata_o = 32'h0000_0000;
    case (size_i)
      SZ_BYTE: rdata_o = {24'h00_0000, mem_q[base_s]};
      SZ_HALF: rdata_o = {16'h0000, mem_q[base_s], mem_q[a1_s]};
      default: rdata_o = {mem_q[base_s], mem_q[a1_s], mem_q[a2_s], mem_q[a3_s]};
    endcase
  end

  always_ff @(posedge clock) begin
    if (we_i) begin
      case (size_i)
        SZ_BYTE: mem_q[base_s] <= wdata_i[7:0];
        SZ_HALF: begin
          mem_q[base_s] <= wdata_i[15:8];
          mem_q[a1_s]   <= wdata_i[7:0];
        end
        default: begin
          mem_q[base_s] <= wdata_i[31:24];
          mem_q[a1_s]   <= wdata_i[23:16];
          mem_q[a2_s]   <= wdata_i[15:8];
          mem_q[a3_s]   <= wdata_i[7:0];
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: IDLE/WAIT/RESP FSM with programmable
// wait states. Define MEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned accesses.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          busy_q;
  logic          err_q;
  logic          mis_q;

  logic          idle_s;
  logic          commit_s;
  logic          cur_wr_s;
  logic [AW-1:0] cur_addr_s;
  logic [1:0]    cur_size_s;
  logic [31:0]   cur_wdata_s;
  logic          mis_s;
  logic          we_s;
  logic [31:0]   arr_rdata_s;
  logic          unused_addr_s;

  // With zero wait states the commit edge is the accept edge, so use live inputs
  assign idle_s      = (state_q == IDLE);
  assign cur_wr_s    = idle_s ? wr             : wr_q;
  assign cur_addr_s  = idle_s ? addr[AW-1:0]   : addr_q;
  assign cur_size_s  = idle_s ? size           : size_q;
  assign cur_wdata_s = idle_s ? wdata          : wdata_q;
  assign commit_s    = (idle_s && req && (WAIT_CYCLES == 0)) ||
                       ((state_q == WAIT) && (cnt_q == 4'd1));

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign mis_s = is_misaligned(cur_size_s, cur_addr_s[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  assign we_s          = commit_s && cur_wr_s && !mis_s;
  assign unused_addr_s = ^addr[31:AW];

  mem_resp_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_array (
    .clock  (clock),
    .we_i   (we_s),
    .addr_i (cur_addr_s),
    .size_i (cur_size_s),
    .wdata_i(cur_wdata_s),
    .rdata_o(arr_rdata_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (commit_s) begin
        mis_q <= mis_s;
        if (mis_s) begin
          rdata_q <= 32'h0000_0000;
        end else if (!cur_wr_s) begin
          rdata_q <= arr_rdata_s;
        end
      end
      case (state_q)
        IDLE: begin
          busy_q <= req;
          if (req) begin
            wr_q    <= wr;
            addr_q  <= addr[AW-1:0];
            size_q  <= size;
            wdata_q <= wdata;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          // Strobe lands in the first IDLE cycle, where a new request may be taken
          ready_q <= 1'b1;
          err_q   <= mis_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with one wait state for data
// and alignment checks, one with two wait states for held-request timing.
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int W1 = 1;
  localparam int W2 = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req1, req2, wr;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic [31:0] rdata1, rdata2;
  logic        ready1, busy1, err1, ready2, busy2, err2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] model_rdata;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clock = ~clock;

  mem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(W1)) u_dut1 (
    .clock(clock), .reset(reset), .req(req1), .wr(wr), .addr(addr), .size(size),
    .wdata(wdata), .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1)
  );

  mem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(W2)) u_dut2 (
    .clock(clock), .reset(reset), .req(req2), .wr(wr), .addr(addr), .size(size),
    .wdata(wdata), .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clock) begin
    if (ready1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ready", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rdata", rdata1, mon_e.rdata);
        check("err", {31'd0, err1}, {31'd0, mon_e.err});
      end
    end
  end

  // Called at a negedge; returns at the negedge where ready1 is seen.
  task automatic access(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    int   lat;
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    model_rdata = exp_rd;
    req1 = 1'b1; wr = w; addr = a; size = s; wdata = d;
    @(posedge clock);
    @(negedge clock);
    req1 = 1'b0;
    lat  = 0;
    while (!ready1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("latency", 32'(lat), 32'(W1 + 1));
  endtask

  task automatic wr_acc(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    access(1'b1, a, s, d, model_rdata, 1'b0);
  endtask

  task automatic rd_acc(input logic [31:0] a, input logic [1:0] s, input logic [31:0] exp_rd);
    access(1'b0, a, s, 32'h0000_0000, exp_rd, 1'b0);
  endtask

  initial begin
    int  pulses;
    logic exp_rdy, exp_bsy;
    req1 = 1'b0; req2 = 1'b0; wr = 1'b0; addr = 32'h0; size = SZ_WORD; wdata = 32'h0;
    model_rdata = 32'h0;
    #12;
    check("rst_rdata", rdata1, 32'h0);
    check("rst_ready", {31'd0, ready1}, 32'd0);
    check("rst_busy",  {31'd0, busy1},  32'd0);
    check("rst_err",   {31'd0, err1},   32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    wr_acc(32'h10, SZ_WORD, 32'hDEAD_BEEF);
    rd_acc(32'h10, SZ_WORD, 32'hDEAD_BEEF);
    wr_acc(32'h11, SZ_BYTE, 32'h0000_0055);
    rd_acc(32'h10, SZ_WORD, 32'hDE55_BEEF);
    rd_acc(32'h13, SZ_BYTE, 32'h0000_00EF);
    rd_acc(32'h12, SZ_HALF, 32'h0000_BEEF);
    wr_acc(32'h14, SZ_WORD, 32'h1122_3344);
    wr_acc(32'h16, SZ_HALF, 32'h0000_A1B2);
    rd_acc(32'h14, SZ_WORD, 32'h1122_A1B2);
    wr_acc(32'h100, SZ_WORD, 32'h1234_5678);
    rd_acc(32'h000, SZ_WORD, 32'h1234_5678);
    wr_acc(32'h20, SZ_WORD, 32'hCAFE_F00D);
    rd_acc(32'h20, SZ_WORD, 32'hCAFE_F00D);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    access(1'b1, 32'h22, SZ_WORD, 32'h0BAD_F00D, 32'h0, 1'b1);
    rd_acc(32'h20, SZ_WORD, 32'hCAFE_F00D);
    access(1'b0, 32'h13, SZ_HALF, 32'h0, 32'h0, 1'b1);
`else
    wr_acc(32'h22, SZ_WORD, 32'h0BAD_F00D);
    rd_acc(32'h20, SZ_WORD, 32'h0BAD_F00D);
    rd_acc(32'h13, SZ_HALF, 32'h0000_BEEF);
`endif
    rd_acc(32'h10, SZ_WORD, 32'hDE55_BEEF);

    // Reset arrives while a write is waiting; the write must be lost
    req1 = 1'b1; wr = 1'b1; addr = 32'h10; size = SZ_WORD; wdata = 32'h9999_9999;
    @(posedge clock);
    #2;
    check("wait_busy", {31'd0, busy1}, 32'd1);
    reset = 1'b0;
    #1;
    check("arst_rdata", rdata1, 32'h0);
    check("arst_busy",  {31'd0, busy1},  32'd0);
    check("arst_ready", {31'd0, ready1}, 32'd0);
    check("arst_err",   {31'd0, err1},   32'd0);
    req1 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_rdata = 32'h0;
    @(negedge clock);
    rd_acc(32'h10, SZ_WORD, 32'hDE55_BEEF);

    // Held request on the two-wait-state instance: accepts every fourth edge
    @(negedge clock);
    req2 = 1'b1; wr = 1'b0; addr = 32'h40; size = SZ_WORD;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      exp_rdy = (i == 3) || (i == 7) || (i == 11);
      exp_bsy = (i <= 10) && !exp_rdy;
      check($sformatf("ready2_c%0d", i), {31'd0, ready2}, {31'd0, exp_rdy});
      check($sformatf("busy2_c%0d", i),  {31'd0, busy2},  {31'd0, exp_bsy});
      if (ready2) begin
        pulses++;
        check("err2", {31'd0, err2}, 32'd0);
      end
      if (i == 8) req2 = 1'b0;
    end
    check("pulse_count", 32'(pulses), 32'd3);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
